serial_adder: RTL

Multi-cycle, parametrised adder/subtractor that processes WIDTH-bit operands BITS_PER_CYCLE bits per clock through a carry register. It replaces the single-bit, purely combinational full adder built from two half adders and an OR gate. It is intended for area-constrained datapaths that can tolerate a WIDTH/BITS_PER_CYCLE-cycle latency. A start/busy/done handshake decouples it from the requester.

---
 rtl/serial_adder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder
// Multi-cycle adder/subtractor. Operands are consumed BITS_PER_CYCLE bits per
// clock through a carry register, so a WIDTH-bit operation takes
// WIDTH/BITS_PER_CYCLE beats. A start/busy/done handshake fronts the datapath.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  request, sampled only in IDLE or DONE
//   i_a      operand A, captured on the accepting edge
//   i_b      operand B, captured on the accepting edge
//   i_cin    carry-in for add (ignored when i_sub=1)
//   i_sub    0: a+b+cin, 1: a-b (as a+~b+1)
//   o_busy   high while beats are being processed
//   o_done   one-cycle pulse, results valid
//   o_sum    result, held until the next operation completes
//   o_cout   carry out of the MSB (for subtract, 1 = no borrow)
//   o_ovf    two's-complement overflow
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for i_start
// S_RUN  | one beat per clock, counter selects the final beat
// S_DONE | results just updated, o_done high; may accept a new start

module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || K < 1 || (WIDTH % K) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [K:0]       w_slice;
    logic             w_carry_msb;
    logic [WIDTH-1:0] w_res_next;

    assign w_last  = (r_cnt == LAST);
    assign w_slice = {1'b0, r_opa[K-1:0]} + {1'b0, r_opb[K-1:0]} + {{K{1'b0}}, r_carry};

    // Carry into the top bit of the slice, recovered from its sum bit:
    // s = a ^ b ^ c  =>  c = s ^ a ^ b. Avoids a second narrower adder.
    assign w_carry_msb = w_slice[K-1] ^ r_opa[K-1] ^ r_opb[K-1];

    // Result fills from the top so that after N beats slice 0 sits at the LSBs.
    generate
        if (N == 1) begin : g_res_one
            assign w_res_next = w_slice[K-1:0];
        end else begin : g_res_many
            assign w_res_next = {w_slice[K-1:0], r_res[WIDTH-1:K]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= i_a;
            r_opb   <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub | i_cin;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_slice[K];
            r_res   <= w_res_next;
            r_opa   <= r_opa >> K;
            r_opb   <= r_opb >> K;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_slice[K];
                r_ovf  <= w_carry_msb ^ w_slice[K];
            end
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule
